// File: rtl/ps2_break_seq_if.sv
// ps2_break_seq_if: byte-in / key-event-out bundle for the PS2 make/break sequencer.
//   rx_done_tick, dout       : byte pulse and data from the PS2 receiver
//   code, brk_stb, make_stb  : key code and its release/press strobes toward the decoder
//   err_stb, err_cnt, busy   : framing/timeout error pulse, saturating count, prefix pending
interface ps2_break_seq_if;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic [7:0] code;
  logic       brk_stb;
  logic       make_stb;
  logic       err_stb;
  logic [7:0] err_cnt;
  logic       busy;
  modport master (output rx_done_tick, dout, input code, brk_stb, make_stb, err_stb, err_cnt, busy);
  modport slave  (input rx_done_tick, dout, output code, brk_stb, make_stb, err_stb, err_cnt, busy);
endinterface

// File: rtl/ps2_break_seq.sv
// ps2_break_seq: make/break framing sequencer between the PS2 byte receiver and the scan-code decoder.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : ps2_break_seq_if.slave (byte input, code/strobes/error count/busy outputs)
//   PS2_EXT_FILTER_EN : when defined, extended (E0-prefixed) make/break keys load no code and raise no strobe
module ps2_break_seq #(
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int CNT_W       = 21
) (
  input logic            clk,
  input logic            reset,
  ps2_break_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  localparam logic [7:0] F0 = 8'hF0;
  localparam logic [7:0] E0 = 8'hE0;
  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             is_f0, is_e0, tmo, err_ev;
  assign is_f0    = bus.dout == F0;
  assign is_e0    = bus.dout == E0;
  assign tmo      = state != IDLE && timer == CNT_W'(TIMEOUT_CYC - 1);
  // A byte arriving in the timeout cycle takes priority, so the timeout only counts without a tick.
  assign err_ev   = bus.rx_done_tick ? ((state == BRK && is_e0) || (state == EXT_BRK && (is_f0 || is_e0)))
                                     : tmo;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      bus.code     <= 8'h00;
      bus.brk_stb  <= 1'b0;
      bus.make_stb <= 1'b0;
      bus.err_stb  <= 1'b0;
      bus.err_cnt  <= 8'h00;
    end else begin
      bus.brk_stb  <= 1'b0;
      bus.make_stb <= 1'b0;
      bus.err_stb  <= err_ev;
      if (err_ev && bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
      if (bus.rx_done_tick) begin
        timer <= '0;
        case (state)
          IDLE:
            if (is_f0) state <= BRK;
            else if (is_e0) state <= EXT;
            else begin
              bus.code     <= bus.dout;
              bus.make_stb <= 1'b1;
            end
          BRK:
            if (is_e0) state <= EXT;
            else if (!is_f0) begin
              bus.code    <= bus.dout;
              bus.brk_stb <= 1'b1;
              state       <= IDLE;
            end
          EXT:
            if (is_f0) state <= EXT_BRK;
            else if (!is_e0) begin
`ifdef PS2_EXT_FILTER_EN
`else
              bus.code     <= bus.dout;
              bus.make_stb <= 1'b1;
`endif
              state <= IDLE;
            end
          EXT_BRK: begin
            if (!is_f0 && !is_e0) begin
`ifdef PS2_EXT_FILTER_EN
`else
              bus.code    <= bus.dout;
              bus.brk_stb <= 1'b1;
`endif
            end
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE) begin
        if (tmo) begin
          state <= IDLE;
          timer <= '0;
        end else timer <= timer + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_break_seq.sv
// tb_ps2_break_seq: directed and randomized bench for ps2_break_seq against a prefix-flag reference model.
module tb_ps2_break_seq;
  localparam int T = 40;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  ps2_break_seq_if bus();
  ps2_break_seq #(.TIMEOUT_CYC(T), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  int errors = 0;
  int checks = 0;
  bit m_brk, m_ext, m_make_s, m_brk_s, m_err_s;
  int m_idle, m_errs;
  logic [7:0] m_code;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_make_s = 0; m_brk_s = 0; m_err_s = 0;
    m_idle = 0; m_errs = 0; m_code = 8'h00;
  endtask
  task automatic fault();
    m_err_s = 1;
    if (m_errs < 255) m_errs++;
  endtask
  task automatic emit(input bit brk, input logic [7:0] b, input bit ext);
`ifdef PS2_EXT_FILTER_EN
    if (ext) return;
`endif
    m_code = b;
    if (brk) m_brk_s = 1; else m_make_s = 1;
  endtask
  // Pending-prefix flags: m_brk = F0 outstanding, m_ext = E0 outstanding; m_idle = idle cycles since last byte.
  task automatic model(input bit tk, input logic [7:0] b);
    bit pend, pre;
    pend = m_brk | m_ext;
    pre = (b == 8'hF0) || (b == 8'hE0);
    m_make_s = 0; m_brk_s = 0; m_err_s = 0;
    if (tk) begin
      m_idle = 0;
      if (!pend) begin
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else emit(0, b, 0);
      end else if (!m_ext) begin
        if (b == 8'hE0) begin fault(); m_brk = 0; m_ext = 1; end
        else if (b != 8'hF0) begin emit(1, b, 0); m_brk = 0; end
      end else if (!m_brk) begin
        if (b == 8'hF0) m_brk = 1;
        else if (b != 8'hE0) begin emit(0, b, 1); m_ext = 0; end
      end else begin
        if (pre) fault(); else emit(1, b, 1);
        m_brk = 0; m_ext = 0;
      end
    end else if (pend) begin
      m_idle++;
      if (m_idle == T) begin fault(); m_brk = 0; m_ext = 0; m_idle = 0; end
    end
  endtask
  task automatic check_all();
    chk("code", bus.code, m_code);
    chk("brk_stb", bus.brk_stb, m_brk_s);
    chk("make_stb", bus.make_stb, m_make_s);
    chk("err_stb", bus.err_stb, m_err_s);
    chk("err_cnt", bus.err_cnt, m_errs);
    chk("busy", bus.busy, m_brk | m_ext);
  endtask
  task automatic step(input bit tk, input logic [7:0] b);
    bus.rx_done_tick = tk;
    bus.dout = tk ? b : 8'($urandom);
    model(tk, b);
    @(posedge clk);
    #1;
    bus.rx_done_tick = 1'b0;
    check_all();
  endtask
  initial begin
    int r;
    bus.rx_done_tick = 1'b0;
    bus.dout = 8'h00;
    model_reset();
    #12;
    check_all();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    // release of key 1C
    step(1, 8'hF0);
    chk("t1_busy", bus.busy, 1);
    step(1, 8'h1C);
    chk("t1_code", bus.code, 8'h1C);
    chk("t1_brk", bus.brk_stb, 1);
    step(0, 8'h00);
    chk("t1_brk_off", bus.brk_stb, 0);
    // plain make
    step(1, 8'h1A);
    chk("t2_make", bus.make_stb, 1);
    chk("t2_code", bus.code, 8'h1A);
    // timeout after F0
    step(1, 8'hF0);
    repeat (T - 1) step(0, 8'h00);
    chk("t3_no_early_err", bus.err_stb, 0);
    step(0, 8'h00);
    chk("t3_err", bus.err_stb, 1);
    chk("t3_cnt", bus.err_cnt, 1);
    chk("t3_busy", bus.busy, 0);
    step(1, 8'h22);
    chk("t3_code", bus.code, 8'h22);
    chk("t3_make", bus.make_stb, 1);
    // extended break
    step(1, 8'hE0);
    step(1, 8'hF0);
    step(1, 8'h23);
`ifdef PS2_EXT_FILTER_EN
    chk("t4_code", bus.code, 8'h22);
    chk("t4_brk", bus.brk_stb, 0);
`else
    chk("t4_code", bus.code, 8'h23);
    chk("t4_brk", bus.brk_stb, 1);
`endif
    // randomized traffic with occasional long gaps
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) repeat ($urandom_range(T - 3, T + 2)) step(0, 8'h00);
      else if (r < 45) step(0, 8'h00);
      else begin
        r = $urandom_range(0, 9);
        step(1, r < 3 ? 8'hF0 : r < 5 ? 8'hE0 : 8'($urandom));
      end
    end
    // reset in the middle of a break sequence
    step(1, 8'hF0);
    reset = 1'b0;
    #2;
    model_reset();
    check_all();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    step(1, 8'h1C);
    chk("t5_brk", bus.brk_stb, 0);
    chk("t5_make", bus.make_stb, 1);
    chk("t5_cnt", bus.err_cnt, 0);
    // saturation of the error counter
    for (int i = 0; i < 260; i++) begin
      step(1, 8'hF0);
      step(1, 8'hE0);
    end
    chk("t6_sat", bus.err_cnt, 8'hFF);
    // byte arrives in the very cycle the timeout would fire
    step(1, 8'hF0);
    repeat (T - 1) step(0, 8'h00);
    step(1, 8'h1C);
    chk("t6_coinc_err", bus.err_stb, 0);
    chk("t6_coinc_brk", bus.brk_stb, 1);
    step(0, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
